// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : jk_bank_arbiter
//  Purpose  : Round-robin arbitration of NREQ requesters onto one shared
//             WIDTH-bit bank of JK flip-flops. The winning requester's
//             {J,K} command and per-bit mask are latched at grant. They are
//             applied one cycle later, and the requester is acknowledged
//             with a one-cycle ACK pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        REQ,
    input  logic [2*NREQ-1:0]      CMD,
    input  logic [WIDTH*NREQ-1:0]  MASK,
    output logic [NREQ-1:0]        GNT,
    output logic [NREQ-1:0]        ACK,
    output logic                   BUSY,
    output logic [WIDTH-1:0]       Q,
    output logic [WIDTH-1:0]       Q_bar
);

    localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_GRANT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [c_PW-1:0]  r_ptr;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_ack;
    logic             r_busy;
    logic [WIDTH-1:0] r_q;
    logic [1:0]       r_cmd;
    logic [WIDTH-1:0] r_mask;

    logic [1:0]       w_state_nxt;
    logic [NREQ-1:0]  w_gnt_nxt;
    logic [NREQ-1:0]  w_ack_nxt;
    logic             w_busy_nxt;
    logic             w_latch;
    logic             w_apply;
    logic             w_found;
    logic [c_PW-1:0]  w_win;
    logic [c_PW:0]    w_idx;
    logic [c_PW-1:0]  w_ptr_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    // Round-robin search: the candidate closest to the pointer (with wrap) wins.
    // Scanning from the farthest offset down lets the nearest hit overwrite.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (c_PW+1)'(k);
            if (w_idx >= (c_PW+1)'(NREQ)) begin
                w_idx = w_idx - (c_PW+1)'(NREQ);
            end
            if (REQ[w_idx[c_PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_PW-1:0];
            end
        end
        w_ptr_nxt = (w_win == c_PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    end

    // Per-bit JK update of the bank using the latched command and mask.
    always_comb begin
        w_q_nxt = r_q;
        for (int b = 0; b < WIDTH; b++) begin
            if (r_mask[b]) begin
                case (r_cmd)
                    2'b01:   w_q_nxt[b] = 1'b0;
                    2'b10:   w_q_nxt[b] = 1'b1;
                    2'b11:   w_q_nxt[b] = ~r_q[b];
                    default: w_q_nxt[b] = r_q[b];
                endcase
            end
        end
    end

    // Sequencer next-state and registered-output values.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = '0;
        w_busy_nxt  = r_busy;
        w_latch     = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_gnt_nxt  = '0;
                w_busy_nxt = 1'b0;
                if (w_found) begin
                    w_state_nxt = c_S_GRANT;
                    w_gnt_nxt   = NREQ'(1) << w_win;
                    w_busy_nxt  = 1'b1;
                    w_latch     = 1'b1;
                end
            end
            c_S_GRANT: begin
                w_state_nxt = c_S_DONE;
                w_gnt_nxt   = '0;
                w_ack_nxt   = r_gnt;
                w_busy_nxt  = 1'b1;
                w_apply     = 1'b1;
            end
            c_S_DONE: begin
                w_state_nxt = c_S_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, outputs, pointer, latched command and bank registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_S_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_q     <= '0;
            r_cmd   <= 2'b00;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            if (w_latch) begin
                r_ptr  <= w_ptr_nxt;
                r_cmd  <= CMD[2*w_win +: 2];
                r_mask <= MASK[WIDTH*w_win +: WIDTH];
            end
            if (w_apply) begin
                r_q <= w_q_nxt;
            end
        end
    end

    assign GNT   = r_gnt;
    assign ACK   = r_ack;
    assign BUSY  = r_busy;
    assign Q     = r_q;
    // The complement is taken combinationally so that it never lags Q.
    assign Q_bar = ~r_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_bank_arbiter
//  Purpose  : Directed self-checking bench for jk_bank_arbiter (NREQ=4,
//             WIDTH=8) with hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  CLK;
    logic                  RST;
    logic [NREQ-1:0]       REQ;
    logic [2*NREQ-1:0]     CMD;
    logic [WIDTH*NREQ-1:0] MASK;
    logic [NREQ-1:0]       GNT;
    logic [NREQ-1:0]       ACK;
    logic                  BUSY;
    logic [WIDTH-1:0]      Q;
    logic [WIDTH-1:0]      Q_bar;

    int n_checks = 0;
    int n_fail   = 0;

    jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) u_dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .CMD   (CMD),
        .MASK  (MASK),
        .GNT   (GNT),
        .ACK   (ACK),
        .BUSY  (BUSY),
        .Q     (Q),
        .Q_bar (Q_bar)
    );

    // Free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_q(input string tag, input logic [7:0] exp_q);
        logic [7:0] nq;
        nq = ~exp_q;
        chk_val({tag, "_q"}, Q, exp_q);
        chk_val({tag, "_qbar"}, Q_bar, nq);
    endtask

    // Single isolated operation from requester r; REQ is dropped after grant.
    task automatic do_op(input string tag, input int r, input logic [1:0] cmd,
                         input logic [7:0] mask, input logic [7:0] exp_q);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << r;
        CMD[2*r +: 2]  = cmd;
        MASK[8*r +: 8] = mask;
        REQ = oh;
        tick();
        chk_val({tag, "_gnt"}, GNT, oh);
        chk_val({tag, "_busy1"}, BUSY, 1);
        chk_val({tag, "_ack0"}, ACK, 0);
        REQ = '0;
        tick();
        chk_q(tag, exp_q);
        chk_val({tag, "_ack"}, ACK, oh);
        chk_val({tag, "_gnt0"}, GNT, 0);
        tick();
        chk_val({tag, "_busy0"}, BUSY, 0);
        chk_val({tag, "_ackclr"}, ACK, 0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    logic [7:0]      exp_q;
    logic [NREQ-1:0] exp_oh;
    int              order4 [5] = '{0, 1, 2, 3, 0};
    int              order6 [4] = '{0, 2, 0, 2};

    initial begin
        RST  = 1'b0;
        REQ  = '0;
        CMD  = '0;
        MASK = '0;
        #1;

        // 1. Reset and idle values.
        do_reset();
        chk_q("rst", 8'h00);
        chk_val("rst_gnt", GNT, 0);
        chk_val("rst_ack", ACK, 0);
        chk_val("rst_busy", BUSY, 0);

        // 1b. Reset during GRANT aborts the command.
        CMD[1:0]  = 2'b10;
        MASK[7:0] = 8'hFF;
        REQ       = 4'b0001;
        tick();
        chk_val("abort_gnt", GNT, 4'b0001);
        RST = 1'b1;
        REQ = '0;
        tick();
        RST = 1'b0;
        chk_q("abort", 8'h00);
        chk_val("abort_ack", ACK, 0);
        chk_val("abort_gnt0", GNT, 0);
        chk_val("abort_busy", BUSY, 0);
        tick();
        chk_val("abort_ack_late", ACK, 0);
        chk_q("abort_late", 8'h00);

        // 2. Single set, then 3. toggle / reset / hold.
        do_op("set",    0, 2'b10, 8'h0F, 8'h0F);
        do_op("toggle", 0, 2'b11, 8'hFF, 8'hF0);
        do_op("clear",  0, 2'b01, 8'h30, 8'hC0);
        do_op("hold",   0, 2'b00, 8'hFF, 8'hC0);
        do_op("masked", 0, 2'b11, 8'h00, 8'hC0);

        // 4. Round-robin with all four requesting; pointer starts at 0.
        do_reset();
        CMD   = 8'b11_11_11_11;
        MASK  = {4{8'h01}};
        REQ   = 4'b1111;
        exp_q = 8'h00;
        for (int i = 0; i < 5; i++) begin
            exp_oh = NREQ'(1) << order4[i];
            tick();
            chk_val("rr_gnt", GNT, exp_oh);
            tick();
            exp_q[0] = ~exp_q[0];
            chk_val("rr_ack", ACK, exp_oh);
            chk_q("rr", exp_q);
            tick();
            chk_val("rr_busy0", BUSY, 0);
        end
        REQ = '0;
        tick();
        chk_val("rr_idle_gnt", GNT, 0);

        // 5. Late CMD/MASK/REQ change after grant is ignored (pointer now 1).
        CMD[3:2]   = 2'b10;
        MASK[15:8] = 8'hF0;
        REQ        = 4'b0010;
        tick();
        chk_val("late_gnt", GNT, 4'b0010);
        CMD[3:2]   = 2'b01;
        MASK[15:8] = 8'hFF;
        REQ        = '0;
        tick();
        chk_val("late_ack", ACK, 4'b0010);
        chk_q("late", 8'hF1);
        tick();
        chk_val("late_busy0", BUSY, 0);

        // 6. Held REQ from 0 and 2 alternates grants; pointer starts at 0.
        do_reset();
        CMD        = '0;
        MASK       = '0;
        CMD[1:0]   = 2'b11;
        MASK[7:0]  = 8'h01;
        CMD[5:4]   = 2'b11;
        MASK[23:16] = 8'h02;
        REQ        = 4'b0101;
        exp_q      = 8'h00;
        for (int i = 0; i < 4; i++) begin
            exp_oh = NREQ'(1) << order6[i];
            tick();
            chk_val("alt_gnt", GNT, exp_oh);
            tick();
            exp_q = exp_q ^ ((order6[i] == 0) ? 8'h01 : 8'h02);
            chk_val("alt_ack", ACK, exp_oh);
            chk_q("alt", exp_q);
            tick();
        end
        REQ = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one WIDTH-bit bank of JK flip-flops between NREQ requesters.
- Each requester issues a JK command (hold/reset/set/toggle) with a per-bit mask.
- A round-robin arbiter grants one requester at a time. A 3-state sequencer applies the granted command to the bank and acknowledges it.
- Sits between control FSMs and the shared status/flag register built from JK flip-flops.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of JK flip-flops in the bank.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- REQ  input  NREQ  request per requester; level, held until ACK.
- CMD  input  2*NREQ  packed {J,K} per requester; requester i uses bits [2i+1:2i], J is the upper bit.
- MASK  input  WIDTH*NREQ  packed per-bit enable; requester i uses bits [WIDTH*i+WIDTH-1:WIDTH*i].
- GNT  output  NREQ  one-hot grant.
- ACK  output  NREQ  one-hot, one-cycle pulse: the command has been applied.
- BUSY  output  1  high whenever state is not IDLE.
- Q  output  WIDTH  JK bank state.
- Q_bar  output  WIDTH  always ~Q, in the same cycle as Q (no one-cycle lag).

Behaviour:
- Reset (RST high at an edge):
  - state=IDLE, Q=0, Q_bar=all ones, GNT=0, ACK=0, BUSY=0, round-robin pointer=0.
  - Overrides everything, including mid-operation. A command in GRANT is aborted: no Q update, no ACK.
- States:
  - IDLE: if REQ!=0, select the first set REQ bit searching from pointer upward with wrap (pointer, pointer+1, ..., NREQ-1, 0, ...). On that edge, register GNT=onehot(winner), latch the winner's CMD and MASK, set pointer=(winner+1) mod NREQ, go to GRANT. If REQ=0, stay in IDLE.
  - GRANT: at the next edge, update Q per the latched command, clear GNT, pulse ACK=onehot(winner), go to DONE.
  - DONE: ACK is high during this cycle; REQ is ignored. At the next edge, clear ACK and go to IDLE.
- Per-bit update in the GRANT->DONE edge. For bit b with MASK bit=1:
  - {J,K}=00: hold.
  - {J,K}=01: Q[b]<=0.
  - {J,K}=10: Q[b]<=1.
  - {J,K}=11: Q[b]<=~Q[b].
  - MASK bit=0: hold, regardless of CMD.
- Latency:
  - REQ sampled at edge n gives GNT high in cycle n+1.
  - Q updated and ACK high in cycle n+2.
  - Arbiter free again at edge n+3, so the minimum issue interval is 3 cycles.
- Command and mask are latched at grant. Changing CMD/MASK or dropping REQ after grant has no effect; the latched command still completes and is ACKed.
- A requester must drop REQ during its ACK cycle or be re-arbitrated. If it keeps REQ high, it competes normally; fairness comes from the pointer.
- Simultaneous requests: exactly one grant. With all NREQ requesting continuously, grants rotate 0,1,...,NREQ-1,0,...
- Pointer wrap: winner NREQ-1 sets pointer=0.
- Outputs GNT, ACK and BUSY are registered. Q_bar is combinational ~Q.
- Invariants: GNT and ACK are never both nonzero. At most one bit of each is set.

Test Plan:
1. Reset then idle: RST=1 for 2 cycles, REQ=0 -> Q=8'h00, Q_bar=8'hFF, GNT=0, ACK=0, BUSY=0. Assert RST while in GRANT -> Q unchanged, no ACK pulse.
2. Single set: REQ=4'b0001, CMD0=10, MASK0=8'h0F -> GNT=0001 in cycle n+1; Q=8'h0F and ACK=0001 in cycle n+2; BUSY low at n+3.
3. Toggle/reset/hold: from Q=8'h0F, apply CMD=11 with MASK=8'hFF -> Q=8'hF0. Then CMD=01 with MASK=8'h30 -> Q=8'hC0. Then CMD=00 with MASK=8'hFF -> Q=8'hC0.
4. Round-robin: REQ=4'b1111 held, all CMD=11, MASK=8'h01 -> grant order 0,1,2,3,0, one grant every 3 cycles. Q[0] toggles on each ACK.
5. Late-change immunity: after GNT, change CMD to 01 and drop REQ -> the originally latched set is applied and ACK still pulses.
6. Held REQ after ACK: REQ=4'b0101 held -> grants alternate 0,2,0,2. Never two consecutive grants to the same requester while the other is requesting.
